vga_timing_gen: RTL
===================

# vga_timing_gen

- Generates 640x480@60 VGA raster timing from the 100 MHz system clock using a divide-by-4 pixel tick.
- Produces registered sync, data-enable and pixel coordinates (x_pixel, y_pixel) for the quad-tile mirror and retro colour stages directly downstream.
- Holds frame-synchronous shadow copies of the mirror controls (mode_quad, mirror_sel), so a mode change never takes effect mid-frame and never tears the image.

## Interface

Parameters:
- DIV, 4: system clocks per pixel (≥2).
- H_VISIBLE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal segment lengths in pixels; H_TOTAL = sum = 800.
- V_VISIBLE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical segment lengths in lines; V_TOTAL = sum = 525.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous reset, active-high.
- mode_quad_req  in  1  requested quad-tile mode.
- mirror_sel_req  in  2  requested mirror select ([0] horizontal, [1] vertical).
- pixel_tick  out  1  one-clk strobe, once per DIV clocks.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- de  out  1  visible-region data enable.
- x_pixel  out  10  column, 0..639 while de, else 0.
- y_pixel  out  10  row, 0..479 while de, else 0.
- frame_start  out  1  one-clk pulse when outputs present pixel (0,0).
- mode_quad  out  1  frame-latched mode_quad_req.
- mirror_sel  out  2  frame-latched mirror_sel_req.

## Operation

- **Divider**
  - div_cnt counts 0..DIV-1 and wraps.
  - pixel_tick is registered and is high for the single clk after div_cnt == DIV-1.
- **Counters**
  - h_count (10 bit, 0..H_TOTAL-1) and v_count (10 bit, 0..V_TOTAL-1) are internal and advance only on cycles where div_cnt == DIV-1.
  - h_count wraps H_TOTAL-1 → 0. v_count increments only when h_count wraps, and itself wraps V_TOTAL-1 → 0.
- **Output decode** (registered, loaded from the current counter values on the same edge the counters advance):
  - de = (h_count < H_VISIBLE) && (v_count < V_VISIBLE).
  - hsync = 0 iff H_VISIBLE+H_FP ≤ h_count < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_VISIBLE+V_FP ≤ v_count < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491.
  - x_pixel = de ? h_count : 0; y_pixel = de ? v_count : 0.
- **Frame start**
  - frame_start = 1 for exactly the clk in which the outputs newly load (h,v) = (0,0); 0 otherwise.
- **Shadow registers**
  - mode_quad and mirror_sel load mode_quad_req / mirror_sel_req on the same edge that raises frame_start; they hold at all other times.
  - A request that is present on that edge takes effect for that frame.
- **Boundary conditions**
  - Requests that toggle mid-frame are ignored until the next frame start; only the value sampled at the frame-start edge matters.
  - End of frame: (799,524) is followed by (0,0), which raises frame_start.
  - Outputs stay constant between pixel_tick updates (DIV clks).
- **Reset**
  - Reset while asserted: div_cnt = 0, h_count = 0, v_count = 0, pixel_tick = 0, hsync = 1, vsync = 1, de = 0, x_pixel = 0, y_pixel = 0, frame_start = 0, mode_quad = 0, mirror_sel = 0.
  - Reset mid-line or mid-frame aborts the current frame immediately; no partial sync pulse persists past the reset edge.

## Timing

- pixel_tick period is DIV clks: first pulse at clk DIV after reset release, then every DIV clks.
- Outputs update on the edge coincident with pixel_tick rising.
- Output latency is one pixel period behind the internal counters. The first update after reset presents (0,0) with de = 1 and frame_start = 1.
- Periods (DIV = 4):
  - Line: 800 pixels = 3200 clk; hsync low for 96 pixels = 384 clk.
  - Frame: 525 lines = 1,680,000 clk; vsync low for 2 lines = 6400 clk.
- de is high for 640 consecutive pixels per visible line, and for 480 lines per frame.
- Shadow-register update is coincident with frame_start; the downstream mirror stage sees new controls starting at pixel (0,0).

## Test plan

- **Reset release:** deassert reset; count clks.
  - pixel_tick first high at clk 4, then every 4 clks.
  - The first update shows x_pixel = 0, y_pixel = 0, de = 1, frame_start = 1, hsync = vsync = 1.
- **Line timing:** run one full line.
  - de is high for pixels 0..639; x_pixel ramps 0..639 then reads 0.
  - hsync is low exactly for pixels 656..751 (384 clk); line length is 3200 clk.
- **Frame timing:** run 2 frames.
  - vsync is low for lines 490..491 only; y_pixel ramps 0..479.
  - frame_start pulses are exactly 1,680,000 clk apart, each 1 clk wide.
- **Mirror shadowing:**
  - Set mode_quad_req = 1, mirror_sel_req = 2'b11 at line 100: outputs stay 0/00 until the next frame_start, then become 1/11.
  - Toggle the requests again mid-frame: no change until the following frame.
- **Simultaneous request at frame start:** change mirror_sel_req from 01 to 10 on the exact frame_start edge → mirror_sel = 10 for that frame.
- **Mid-frame reset:** assert reset for 3 clks at line 490 (vsync low).
  - During reset: vsync = 1, de = 0, all counters 0.
  - After release: behaviour matches the reset-release scenario exactly.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing from a divided pixel tick, with frame-latched mirror controls
module vga_timing_gen #(
  parameter int DIV       = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_quad_req,
  input  logic [1:0] mirror_sel_req,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       frame_start,
  output logic       mode_quad,
  output logic [1:0] mirror_sel
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(DIV);
  logic [DW-1:0] div_cnt;
  logic [9:0]    h_count, v_count, h_next, v_next;
  logic          adv, h_end, v_end, vis, hs_act, vs_act, origin;
  // next-count arithmetic and decode of the current counter position
  always_comb begin
    adv    = div_cnt == DW'(DIV - 1);
    h_end  = h_count == 10'(H_TOTAL - 1);
    v_end  = v_count == 10'(V_TOTAL - 1);
    h_next = h_end ? 10'd0 : h_count + 10'd1;
    v_next = h_end ? (v_end ? 10'd0 : v_count + 10'd1) : v_count;
    vis    = (h_count < 10'(H_VISIBLE)) && (v_count < 10'(V_VISIBLE));
    hs_act = (h_count >= 10'(H_VISIBLE + H_FP)) && (h_count < 10'(H_VISIBLE + H_FP + H_SYNC));
    vs_act = (v_count >= 10'(V_VISIBLE + V_FP)) && (v_count < 10'(V_VISIBLE + V_FP + V_SYNC));
    origin = (h_count == 10'd0) && (v_count == 10'd0);
  end
  // pixel divider and raster counters; counters step once per pixel period
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      h_count <= '0;
      v_count <= '0;
    end else begin
      div_cnt <= adv ? '0 : div_cnt + 1'b1;
      if (adv) begin
        h_count <= h_next;
        v_count <= v_next;
      end
    end
  end
  // registered outputs, one pixel period behind the counters they decode
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      x_pixel     <= '0;
      y_pixel     <= '0;
    end else begin
      pixel_tick  <= adv;
      frame_start <= adv && origin;
      if (adv) begin
        de      <= vis;
        hsync   <= !hs_act;
        vsync   <= !vs_act;
        x_pixel <= vis ? h_count : 10'd0;
        y_pixel <= vis ? v_count : 10'd0;
      end
    end
  end
  // mirror controls only change on the frame-start edge so a frame is never torn
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_quad  <= 1'b0;
      mirror_sel <= 2'b00;
    end else if (adv && origin) begin
      mode_quad  <= mode_quad_req;
      mirror_sel <= mirror_sel_req;
    end
  end
endmodule
